vga_rect_engine: RTL and testbench
==================================

Name: vga_rect_engine

Overview:
- Parametrised pixel-plotting engine that drives the simulator/board VGA plot interface (VGA_X, VGA_Y, VGA_COLOR, plot).
- Draws a filled rectangle, an outlined rectangle, or a full-screen clear, emitting one pixel per clock in raster order with screen clipping.
- Sits between demo control logic (switches/keys) and the VGA adapter, replacing hand-written per-demo plotting counters.
- Resolution and colour depth are parameters.

Parameters:
XW, 10, x coordinate width (10 = 640, 9 = 320, 8 = 160)
YW, 9, y coordinate width (XW-1 for the standard resolutions)
H_RES, 640, visible columns; legal x is 0..H_RES-1
V_RES, 480, visible rows; legal y is 0..V_RES-1
CW, 24, colour width

Ports:
CLOCK_50  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
mode  input  2  0=fill, 1=outline, 2=clear screen, 3=reserved (treated as fill)
x0  input  XW  rectangle left column
y0  input  YW  rectangle top row
w  input  XW  rectangle width in pixels
h  input  YW  rectangle height in pixels
color  input  CW  draw colour
abort  input  1  terminate current operation
VGA_X  output  XW  pixel column
VGA_Y  output  YW  pixel row
VGA_COLOR  output  CW  pixel colour
plot  output  1  pixel write strobe, one pixel per high cycle
busy  output  1  high from CLIP through DRAW
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0): state IDLE; VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, busy=0, done=0; latched operands cleared. Reset mid-draw stops plotting immediately; no done pulse.
- All outputs are registered.
- IDLE:
  - When start=1, latch mode/x0/y0/w/h/color and go to CLIP. start is ignored in all other states.
  - Mode 2 replaces the operands with x0=0, y0=0, w=H_RES, h=V_RES.
- CLIP (1 cycle, busy=1):
  - Compute xe=x0+w-1 and ye=y0+h-1 in XW+1 / YW+1 bits; no wrap.
  - Clipped ends: xc=min(xe,H_RES-1), yc=min(ye,V_RES-1).
  - Empty if w=0, h=0, x0>=H_RES, or y0>=V_RES: go to FINISH with no plots.
  - Otherwise set the scan position to (x0,y0) and go to DRAW.
- DRAW (busy=1):
  - Each cycle, present the scan position on VGA_X/VGA_Y with VGA_COLOR=color.
  - Fill: plot=1 for every position.
  - Outline: plot=1 only when x==x0, x==xe, y==y0, or y==ye, using the unclipped ends. A clipped edge therefore produces no pixels. Interior positions are still visited with plot=0.
  - Advance x; at x==xc wrap x to x0 and increment y. At (xc,yc), go to FINISH after that cycle's pixel.
  - Cycle count is exactly (xc-x0+1)*(yc-y0+1) for both fill and outline.
- FINISH (1 cycle): plot=0, busy=0, done=1; return to IDLE. A start on this cycle is ignored.
- abort:
  - In CLIP or DRAW: the next cycle is FINISH; plot=0 from that cycle; done pulses.
  - In IDLE or FINISH: ignored.
  - If abort and start are high together in IDLE, start wins.
- Latency: start high at edge t gives CLIP at t+1 and the first plot registered at t+2. The last pixel at edge T is followed by done at T+1.
- VGA_X/VGA_Y/VGA_COLOR hold their last values while plot=0.
- 1x1 rectangle: exactly one plot cycle in every mode.

Test Plan:
- Fill x0=10,y0=20,w=3,h=2,color=FF0000 -> 6 plots in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); first plot 2 cycles after start; done 1 cycle after the last plot; busy high for 7 cycles.
- Outline x0=0,y0=0,w=4,h=3 -> 12 DRAW cycles, 10 plots; (1,1) and (2,1) have plot=0; done once.
- Clipping, H_RES=640/V_RES=480: fill x0=638,y0=479,w=5,h=5 -> exactly 2 plots, (638,479) and (639,479). Outline with the same operands -> 2 plots (top edge only; the right edge is off-screen).
- Empty and clear: w=0 -> no plot, done 2 cycles after start. Mode 2 with H_RES=160/V_RES=120, XW=8/YW=7 -> 19200 plots, last at (159,119).
- Abort: fill 100x100 with abort high on the 5th plot cycle -> exactly 5 plots, then plot=0 and done pulse on the next cycle. start held high throughout -> a new operation begins only after the return to IDLE.
- Async reset: drive resetn=0 mid-draw between clock edges -> plot, busy, done, VGA_X/Y/COLOR go to 0 without waiting for a clock edge; no done pulse after release; next start operates normally.

Source files
------------

// File: rtl/vga_rect_engine_if.sv
// Request/plot bundle between demo control logic and the rectangle engine.
// The engine sits on the slave side; the controller/bench drives the master side.
interface vga_rect_engine_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int CW = 24
);
  logic          start;
  logic [1:0]    mode;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW-1:0] w;
  logic [YW-1:0] h;
  logic [CW-1:0] color;
  logic          abort;
  logic [XW-1:0] VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [CW-1:0] VGA_COLOR;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, x0, y0, w, h, color, abort,
    input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
  );
  modport slave (
    input  start, mode, x0, y0, w, h, color, abort,
    output VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
  );
endinterface

// File: rtl/vga_rect_engine.sv
// Rectangle fill/outline/clear engine: one pixel per clock in raster order,
// clipped to the visible screen, all outputs registered.
module vga_rect_engine #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW    = 24
) (
  input  logic CLOCK_50,
  input  logic resetn,
  vga_rect_engine_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_DRAW, S_FIN} state_t;

  localparam logic [XW:0] XLIM = (XW+1)'(H_RES - 1);
  localparam logic [YW:0] YLIM = (YW+1)'(V_RES - 1);

  state_t        state_q, state_d;
  logic          outline_q, outline_d;
  logic [XW-1:0] x0_q, x0_d, w_q, w_d, x_q, x_d, vx_q, vx_d;
  logic [YW-1:0] y0_q, y0_d, h_q, h_d, y_q, y_d, vy_q, vy_d;
  logic [CW-1:0] col_q, col_d, vc_q, vc_d;
  logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Unclipped ends carry one extra bit so a rectangle past the edge never wraps.
  logic [XW:0]   xe;
  logic [YW:0]   ye;
  logic [XW-1:0] xc, nx;
  logic [YW-1:0] yc, ny;
  logic          empty, adv, pix;

  assign xe    = {1'b0, x0_q} + {1'b0, w_q} - (XW+1)'(1);
  assign ye    = {1'b0, y0_q} + {1'b0, h_q} - (YW+1)'(1);
  assign xc    = (xe > XLIM) ? XLIM[XW-1:0] : xe[XW-1:0];
  assign yc    = (ye > YLIM) ? YLIM[YW-1:0] : ye[YW-1:0];
  assign empty = (w_q == '0) || (h_q == '0) || ({1'b0, x0_q} > XLIM) || ({1'b0, y0_q} > YLIM);

  always_comb begin
    state_d   = state_q;
    outline_d = outline_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    x_d       = x_q;
    y_d       = y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    vc_d      = vc_q;
    plot_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    nx        = x_q;
    ny        = y_q;
    adv       = 1'b0;
    pix       = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        outline_d = (bus.mode == 2'd1);
        col_d     = bus.color;
        if (bus.mode == 2'd2) begin
          x0_d = '0;
          y0_d = '0;
          w_d  = XW'(H_RES);
          h_d  = YW'(V_RES);
        end else begin
          x0_d = bus.x0;
          y0_d = bus.y0;
          w_d  = bus.w;
          h_d  = bus.h;
        end
        state_d = S_CLIP;
        busy_d  = 1'b1;
      end
      S_CLIP: if (bus.abort || empty) begin
        state_d = S_FIN;
        done_d  = 1'b1;
      end else begin
        nx      = x0_q;
        ny      = y0_q;
        adv     = 1'b1;
        state_d = S_DRAW;
      end
      S_DRAW: if (bus.abort || (x_q == xc && y_q == yc)) begin
        state_d = S_FIN;
        done_d  = 1'b1;
      end else begin
        nx  = (x_q == xc) ? x0_q : x_q + XW'(1);
        ny  = (x_q == xc) ? y_q + YW'(1) : y_q;
        adv = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Outline tests the unclipped ends, so an off-screen edge emits nothing.
    if (adv) begin
      pix    = !outline_q || nx == x0_q || {1'b0, nx} == xe || ny == y0_q || {1'b0, ny} == ye;
      x_d    = nx;
      y_d    = ny;
      busy_d = 1'b1;
      plot_d = pix;
      if (pix) begin
        vx_d = nx;
        vy_d = ny;
        vc_d = col_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      outline_q <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      vc_q      <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      outline_q <= outline_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      vc_q      <= vc_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.VGA_X     = vx_q;
  assign bus.VGA_Y     = vy_q;
  assign bus.VGA_COLOR = vc_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_vga_rect_engine.sv
// Scoreboard bench for vga_rect_engine: 640x480 instance for draw/clip/abort/reset,
// 160x120 instance for the full-screen clear.
module tb_vga_rect_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_rect_engine_if #(.XW(10), .YW(9), .CW(24)) bus ();
  vga_rect_engine #(.XW(10), .YW(9), .H_RES(640), .V_RES(480), .CW(24))
    dut (.CLOCK_50(clk), .resetn(rst_n), .bus(bus));

  vga_rect_engine_if #(.XW(8), .YW(7), .CW(24)) bus2 ();
  vga_rect_engine #(.XW(8), .YW(7), .H_RES(160), .V_RES(120), .CW(24))
    dut2 (.CLOCK_50(clk), .resetn(rst_n), .bus(bus2));

  typedef struct {bit is_done; int x; int y; logic [23:0] c;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_plot_cyc = 0;
  bit had_plot = 0;
  int cnt2 = 0, fx2 = -1, fy2 = -1, lx2 = -1, ly2 = -1;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_px(int x, int y, logic [23:0] c);
    exp_t e;
    e.is_done = 0; e.x = x; e.y = y; e.c = c;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1; e.x = 0; e.y = 0; e.c = '0;
    q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every plot or done pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && (bus.plot || bus.done)) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_unexpected: plot=%0b done=%0b x=%0d y=%0d with empty queue",
                 bus.plot, bus.done, bus.VGA_X, bus.VGA_Y);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_kind_done", bus.done, e.is_done);
        chk("sb_kind_plot", bus.plot, !e.is_done);
        if (!e.is_done) begin
          chk("sb_x", bus.VGA_X, e.x);
          chk("sb_y", bus.VGA_Y, e.y);
          chk("sb_color", bus.VGA_COLOR, e.c);
        end
      end
      if (bus.plot) begin
        had_plot = 1;
        last_plot_cyc = cyc;
      end
      if (bus.done) begin
        if (had_plot) chk("done_after_last_plot", cyc - last_plot_cyc, 1);
        had_plot = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.plot) begin
      cnt2++;
      if (cnt2 == 1) begin fx2 = bus2.VGA_X; fy2 = bus2.VGA_Y; end
      lx2 = bus2.VGA_X;
      ly2 = bus2.VGA_Y;
    end
  end

  // Issue one operation and measure first-plot latency, busy length and done time
  // in cycles after the start edge.
  task automatic run_op(string nm, bit [1:0] m, int x0, int y0, int w, int h,
                        logic [23:0] c, int exp_first, int exp_busy, int exp_done);
    int k, first, busyc;
    @(negedge clk);
    bus.mode = m; bus.x0 = 10'(x0); bus.y0 = 9'(y0); bus.w = 10'(w); bus.h = 9'(h);
    bus.color = c; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; first = -1; busyc = 0;
    while (!bus.done && k < 2000) begin
      if (bus.plot && first < 0) first = k;
      if (bus.busy) busyc++;
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, k);
    end
    chk({nm, "_first_plot"}, first, exp_first);
    chk({nm, "_busy_cycles"}, busyc, exp_busy);
    chk({nm, "_done_cycle"}, k, exp_done);
    @(negedge clk);
    chk({nm, "_done_single"}, bus.done, 0);
    chk({nm, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    int n, k;
    bus.start = 0; bus.mode = 0; bus.x0 = 0; bus.y0 = 0; bus.w = 0; bus.h = 0;
    bus.color = 0; bus.abort = 0;
    bus2.start = 0; bus2.mode = 0; bus2.x0 = 0; bus2.y0 = 0; bus2.w = 0; bus2.h = 0;
    bus2.color = 0; bus2.abort = 0;
    #23;
    chk("rst_x", bus.VGA_X, 0);
    chk("rst_y", bus.VGA_Y, 0);
    chk("rst_color", bus.VGA_COLOR, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    push_px(10, 20, 24'hFF0000); push_px(11, 20, 24'hFF0000); push_px(12, 20, 24'hFF0000);
    push_px(10, 21, 24'hFF0000); push_px(11, 21, 24'hFF0000); push_px(12, 21, 24'hFF0000);
    push_done();
    run_op("fill3x2", 2'd0, 10, 20, 3, 2, 24'hFF0000, 2, 7, 8);
    chk("hold_x", bus.VGA_X, 12);
    chk("hold_y", bus.VGA_Y, 21);
    chk("hold_color", bus.VGA_COLOR, 24'hFF0000);

    push_px(0, 0, 24'h00FF00); push_px(1, 0, 24'h00FF00); push_px(2, 0, 24'h00FF00);
    push_px(3, 0, 24'h00FF00); push_px(0, 1, 24'h00FF00); push_px(3, 1, 24'h00FF00);
    push_px(0, 2, 24'h00FF00); push_px(1, 2, 24'h00FF00); push_px(2, 2, 24'h00FF00);
    push_px(3, 2, 24'h00FF00);
    push_done();
    run_op("outline4x3", 2'd1, 0, 0, 4, 3, 24'h00FF00, 2, 13, 14);

    push_px(638, 479, 24'h0000AA); push_px(639, 479, 24'h0000AA); push_done();
    run_op("clip_fill", 2'd0, 638, 479, 5, 5, 24'h0000AA, 2, 3, 4);
    push_px(638, 479, 24'h00AA00); push_px(639, 479, 24'h00AA00); push_done();
    run_op("clip_outline", 2'd1, 638, 479, 5, 5, 24'h00AA00, 2, 3, 4);

    push_done();
    run_op("empty_w0", 2'd0, 5, 5, 0, 4, 24'h111111, -1, 1, 2);
    push_done();
    run_op("empty_offscreen", 2'd0, 700, 5, 4, 4, 24'h222222, -1, 1, 2);

    push_px(7, 9, 24'hABCDEF); push_done();
    run_op("one_fill", 2'd0, 7, 9, 1, 1, 24'hABCDEF, 2, 2, 3);
    push_px(8, 9, 24'h123123); push_done();
    run_op("one_outline", 2'd1, 8, 9, 1, 1, 24'h123123, 2, 2, 3);
    push_px(9, 9, 24'h321321); push_done();
    run_op("one_mode3", 2'd3, 9, 9, 1, 1, 24'h321321, 2, 2, 3);

    // Abort on the 5th plot with start held high; the restart is aborted in CLIP.
    for (int i = 0; i < 5; i++) push_px(100 + i, 50, 24'h0000FF);
    push_done();
    push_done();
    @(negedge clk);
    bus.mode = 0; bus.x0 = 100; bus.y0 = 50; bus.w = 100; bus.h = 100;
    bus.color = 24'h0000FF; bus.start = 1'b1;
    n = 0; k = 0;
    while (n < 5 && k < 50) begin
      @(negedge clk);
      k++;
      if (bus.plot) n++;
    end
    chk("abort_plots_seen", n, 5);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_done", bus.done, 1);
    chk("abort_plot_low", bus.plot, 0);
    @(negedge clk);
    chk("abort_start_ignored_in_finish", bus.busy, 0);
    @(negedge clk);
    chk("abort_restart_clip", bus.busy, 1);
    @(negedge clk);
    chk("abort_in_clip_done", bus.done, 1);
    chk("abort_in_clip_plot", bus.plot, 0);
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_back_idle", bus.busy, 0);

    // Full-screen clear on the small instance.
    @(negedge clk);
    bus2.mode = 2'd2; bus2.x0 = 8'd33; bus2.y0 = 7'd44; bus2.w = 8'd1; bus2.h = 7'd1;
    bus2.color = 24'h5A5A5A; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    k = 0;
    while (!bus2.done && k < 25000) begin
      @(negedge clk);
      k++;
    end
    chk("clear_done_seen", bus2.done, 1);
    chk("clear_count", cnt2, 19200);
    chk("clear_first_x", fx2, 0);
    chk("clear_first_y", fy2, 0);
    chk("clear_last_x", lx2, 159);
    chk("clear_last_y", ly2, 119);
    chk("clear_color", bus2.VGA_COLOR, 24'h5A5A5A);

    // Asynchronous reset in the middle of a draw.
    push_px(200, 300, 24'h123456); push_px(201, 300, 24'h123456); push_px(202, 300, 24'h123456);
    @(negedge clk);
    bus.mode = 0; bus.x0 = 200; bus.y0 = 300; bus.w = 50; bus.h = 5;
    bus.color = 24'h123456; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = (bus.plot) ? 1 : 0; k = 0;
    while (n < 3 && k < 50) begin
      @(negedge clk);
      k++;
      if (bus.plot) n++;
    end
    chk("rst_mid_plots_seen", n, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", bus.VGA_X, 0);
    chk("arst_y", bus.VGA_Y, 0);
    chk("arst_color", bus.VGA_COLOR, 0);
    chk("arst_plot", bus.plot, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.plot || bus.busy) n++;
    end
    chk("post_reset_quiet", n, 0);
    chk("sb_queue_empty", q.size(), 0);
    push_px(3, 4, 24'h00FFFF); push_px(4, 4, 24'h00FFFF); push_done();
    run_op("post_reset_fill", 2'd0, 3, 4, 2, 1, 24'h00FFFF, 2, 3, 4);
    chk("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
